// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Debounces and edge-detects one raw push-button input. Debounce and long-press
// windows are counted in ticks of the clock-divider strobe, not in raw clocks.
//
// Optional feature macro: BUTTON_DEBOUNCER_LONG_PRESS_EN
//   defined   -> long_press pulses once after LONG_TICKS ticks of held press
//   undefined -> long_press is tied to 0 and the long-press counter is absent
//
// Parameters
//   STABLE_TICKS   ticks a new synchronized value must hold (1..1023)
//   LONG_TICKS     ticks of continuous press before long_press (1..65535)
//   BTN_ACTIVE_LOW 1: raw 0 means pressed, 0: raw 1 means pressed
//
// Ports
//   CLK        in  system clock, rising edge
//   RST        in  asynchronous active-high reset
//   tick       in  one-cycle time-base strobe (may be high on back-to-back cycles)
//   btn_raw    in  asynchronous pad input
//   level      out debounced state, 1 = pressed
//   press      out one-cycle strobe on accepted 0->1 change of level
//   release_o  out one-cycle strobe on accepted 1->0 change of level
//              ("release" is a reserved word in SystemVerilog)
//   long_press out one-cycle strobe after LONG_TICKS ticks of held press
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module button_debouncer #(
    parameter int STABLE_TICKS   = 20,
    parameter int LONG_TICKS     = 1000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_o,
    output logic long_press
);

    localparam int              CNT_W    = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    // Raw pad level that corresponds to "released"
    localparam logic            RAW_IDLE = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic             accept_press;
    logic             accept_release;

    // Two-flop synchronizer; reset loads the released level so btn_s starts at 0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= RAW_IDLE;
            sync2_q <= RAW_IDLE;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Final qualifying tick of each window. A bounce in the same cycle wins,
    // which falls out of requiring btn_s to still hold the candidate value.
    always_comb begin
        accept_press   = 1'b0;
        accept_release = 1'b0;
        if (state_q == S_PRESS_WAIT && btn_s && tick && cnt_q == CNT_LAST) begin
            accept_press = 1'b1;
        end
        if (state_q == S_RELEASE_WAIT && !btn_s && tick && cnt_q == CNT_LAST) begin
            accept_release = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (btn_s) begin
                        state_q <= S_PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (accept_press) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else if (tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!btn_s) begin
                        state_q <= S_RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (btn_s) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                    end else if (accept_release) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else if (tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign release_o = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int              LCNT_W    = $clog2(LONG_TICKS + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LONG_TICKS);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_TICKS - 1);

    logic [LCNT_W-1:0] lcnt_q;
    logic              long_q;

    // level_q is 1 exactly in PRESSED and RELEASE_WAIT, so it gates counting.
    // A bounce back from RELEASE_WAIT keeps the count; leaving for IDLE clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (accept_press || accept_release || !level_q) begin
                lcnt_q <= '0;
            end else if (tick && lcnt_q != LCNT_MAX) begin
                lcnt_q <= lcnt_q + 1'b1;
                if (lcnt_q == LCNT_LAST) begin
                    long_q <= 1'b1;
                end
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces and edge-detects one raw push-button input using the periodic single-cycle tick produced by the clock divider stage as its time base. The block sits directly downstream of the divider: the divider's one-cycle strobe drives `tick`, so debounce and long-press windows are counted in ticks rather than raw clock cycles. It outputs a clean level, single-cycle press and release strobes, and an optional long-press strobe for the LED/UI logic.

## Interface
- `STABLE_TICKS`, default 20: number of consecutive ticks the synchronized input must hold a new value before it is accepted; legal range 1..1023.
- `LONG_TICKS`, default 1000: ticks of continuous debounced press before `long_press` fires; legal range 1..65535; used only with `LONG_PRESS_EN`.
- `BTN_ACTIVE_LOW`, default 1: 1 means a raw 0 is "pressed"; 0 means a raw 1 is "pressed".

- `CLK`  input  1  system clock; all state changes on its rising edge.
- `RST`  input  1  reset, asynchronous, active-high.
- `tick`  input  1  time-base strobe from the clock divider, one `CLK` cycle wide; may be high on consecutive cycles.
- `btn_raw`  input  1  asynchronous pad input.
- `level`  output  1  debounced state, 1 = pressed.
- `press`  output  1  one-cycle strobe on an accepted 0→1 change of `level`.
- `release`  output  1  one-cycle strobe on an accepted 1→0 change of `level`.
- `long_press`  output  1  one-cycle strobe after `LONG_TICKS` ticks of continuous press.

## Operation
- Synchronizer: two flops on `btn_raw`, then polarity correction: `btn_s` = 1 means pressed. On reset both flops load the released raw level, so `btn_s` = 0.
- FSM states: IDLE (level 0), PRESS_WAIT, PRESSED (level 1), RELEASE_WAIT. Reset → IDLE.
- IDLE: `btn_s`=1 → PRESS_WAIT, `cnt` cleared to 0.
- PRESS_WAIT: `btn_s`=0 → IDLE, `cnt` cleared, no tick needed. Otherwise, on `tick`, if `cnt`==`STABLE_TICKS`-1 → PRESSED, `level`←1, `press`←1; else `cnt`+1.
- PRESSED: `btn_s`=0 → RELEASE_WAIT, `cnt` cleared.
- RELEASE_WAIT: mirror of PRESS_WAIT. `btn_s`=1 → PRESSED, no strobe. Final tick → IDLE, `level`←0, `release`←1.
- If a bounce and a tick occur in the same cycle, the bounce wins: return to the stable state, `cnt` cleared, no increment.
- `cnt` width is $clog2(STABLE_TICKS+1). It never exceeds `STABLE_TICKS`-1.
- `press`, `release` and `long_press` are registered and held high for exactly one cycle. They default to 0 in every cycle where they are not set.
- `level` changes only on PRESS_WAIT→PRESSED and RELEASE_WAIT→IDLE. Bounce excursions never toggle it.

## Timing
- Reset values: `level`, `press`, `release`, `long_press` = 0; state IDLE; all counters 0.
- Asserting `RST` mid-operation aborts immediately. A strobe that was pending is dropped. After reset, a held button must re-qualify through PRESS_WAIT.
- `btn_raw` reaches `btn_s` after 2 `CLK` edges. A clean edge is accepted on the `CLK` edge carrying the `STABLE_TICKS`-th tick counted after `btn_s` changed; `press`/`release` are visible in the following cycle.
- `STABLE_TICKS`=1: the first tick with the candidate value held is accepted.
- With `tick` tied high, windows are counted in raw `CLK` cycles.

## Configuration
- `BUTTON_DEBOUNCER_LONG_PRESS_EN` defined:
  - A `lcnt` counter, width $clog2(LONG_TICKS+1), is cleared on entry to PRESSED.
  - `lcnt` increments on each `tick` while in PRESSED or RELEASE_WAIT.
  - When `lcnt` reaches `LONG_TICKS`, `long_press` pulses once. `lcnt` then saturates; there is no repeat until `level` returns to 0.
  - Entering IDLE clears `lcnt`. A bounce back from RELEASE_WAIT to PRESSED does not clear it.
- Macro undefined: `long_press` is tied to 0 and `lcnt` is not instantiated.

## Test plan
- Reset: assert `RST` with `btn_raw`=1 and `BTN_ACTIVE_LOW`=1 → all outputs 0 and state IDLE during reset and after release.
- Clean press: `STABLE_TICKS`=4, tick every 10 cycles, hold `btn_raw`=0 → exactly one `press` pulse after the 4th tick following synchronization; `level`=1; no `release`.
- Bounce reject: toggle `btn_raw` every 15 cycles for 200 cycles, then return to 1 → `level` stays 0; `press` and `release` never assert.
- Release: from pressed, set `btn_raw`=1 → one `release` pulse after 4 ticks and `level`=0. A glitch to 0 lasting 3 ticks mid-window returns to PRESSED with no strobe.
- Reset mid-window: assert `RST` at tick 2 of PRESS_WAIT → outputs 0. The held button then needs 4 fresh ticks to produce `press`.
- Long press (macro on, `LONG_TICKS`=8): hold pressed for 20 ticks → one `long_press` pulse 8 ticks after `press` and none after. With the macro off → `long_press` is constantly 0.
